// File: rtl/delay_addr_ctrl_if.sv
// delay_addr_ctrl_if
//   Bus between the sample source / RAM side and delay_addr_ctrl.
//   slave  modport: the controller (samples in, RAM strobes out).
//   master modport: whoever drives samples and consumes RAM strobes.
//   Signals:
//     en, offset, sample_in          -> controller
//     wr_en, rd_en, wr_addr, rd_addr,
//     din, dout_valid, filling       <- controller
interface delay_addr_ctrl_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);
  logic                     en;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0]    sample_in;
  logic                     wr_en;
  logic                     rd_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    din;
  logic                     dout_valid;
  logic                     filling;

  modport slave (
    input  en, offset, sample_in,
    output wr_en, rd_en, wr_addr, rd_addr, din, dout_valid, filling
  );

  modport master (
    output en, offset, sample_in,
    input  wr_en, rd_en, wr_addr, rd_addr, din, dout_valid, filling
  );
endinterface

// File: rtl/delay_addr_ctrl.sv
// delay_addr_ctrl
//   Address/strobe controller in front of the dual-port sample RAM of the
//   audio delay line. Each strobe writes the sample at a wrapping write
//   pointer and reads from (write pointer - D) mod N, D = offset or N when
//   offset is 0. Reads are held off until D samples have been written.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - delay_addr_ctrl_if.slave (en/offset/sample_in in;
//              wr_en/rd_en/wr_addr/rd_addr/din/dout_valid/filling out)
//   Build option:
//     DELAY_REFILL_EN - an offset change on a strobe restarts the fill, so
//                       no reads with a stale offset reach the output.
module delay_addr_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  delay_addr_ctrl_if.slave   bus
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ONE   = (ADDRESS_WIDTH+1)'(1);

  typedef enum logic {
    FILL,
    RUN
  } state_e;

  state_e                   state_q,      state_d;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q,     wr_ptr_d;
  logic [ADDRESS_WIDTH:0]   fill_cnt_q,   fill_cnt_d;
  logic                     wr_en_q,      wr_en_d;
  logic                     rd_en_q,      rd_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q,    wr_addr_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q,    rd_addr_d;
  logic [DATA_WIDTH-1:0]    din_q,        din_d;
  logic                     dout_valid_q, dout_valid_d;
`ifdef DELAY_REFILL_EN
  logic [ADDRESS_WIDTH-1:0] offset_q,     offset_d;
`endif

  logic [ADDRESS_WIDTH:0]   eff_delay;
  logic [ADDRESS_WIDTH:0]   delay_m1;

  // offset 0 selects the full buffer depth; its low bits are then 0, so
  // the read address equals the write address (read-before-write).
  always_comb begin
    eff_delay = (bus.offset == '0) ? DEPTH : {1'b0, bus.offset};
    delay_m1  = eff_delay - ONE;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    din_d        = din_q;
    dout_valid_d = rd_en_q;
`ifdef DELAY_REFILL_EN
    offset_d     = offset_q;
`endif

    if (bus.en) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_ptr_q;
      din_d     = bus.sample_in;
      rd_addr_d = wr_ptr_q - eff_delay[ADDRESS_WIDTH-1:0];
      wr_ptr_d  = wr_ptr_q + ADDRESS_WIDTH'(1);
`ifdef DELAY_REFILL_EN
      offset_d  = bus.offset;
      if (bus.offset != offset_q) begin
        // This strobe is the first of the new fill.
        fill_cnt_d = ONE;
        state_d    = (eff_delay == ONE) ? RUN : FILL;
      end else begin
`else
      begin
`endif
        case (state_q)
          FILL: begin
            fill_cnt_d = fill_cnt_q + ONE;
            // >= rather than == so a shrinking offset mid-fill cannot
            // leave the counter stranded above the new target.
            if (fill_cnt_q >= delay_m1) begin
              state_d = RUN;
            end
          end
          RUN: begin
            rd_en_d = 1'b1;
          end
          default: begin
            state_d = FILL;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      din_q        <= '0;
      dout_valid_q <= 1'b0;
`ifdef DELAY_REFILL_EN
      offset_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      din_q        <= din_d;
      dout_valid_q <= dout_valid_d;
`ifdef DELAY_REFILL_EN
      offset_q     <= offset_d;
`endif
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.din        = din_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.filling    = (state_q == FILL);

endmodule

// File: tb/tb_delay_addr_ctrl.sv
// tb_delay_addr_ctrl
//   Directed bench for delay_addr_ctrl with a read-before-write RAM model
//   on the RAM-side outputs so delayed samples can be checked end to end.
module tb_delay_addr_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  delay_addr_ctrl_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus ();

  delay_addr_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous dual-port RAM, old data on a same-address read/write.
  logic [7:0] mem [256];
  logic [7:0] ram_dout;
  always @(posedge clk) begin
    if (bus.rd_en) ram_dout <= mem[bus.rd_addr];
    if (bus.wr_en) mem[bus.wr_addr] <= bus.din;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at
  // the same point, i.e. they reflect the edge just taken.
  task automatic tick(input logic e, input logic [7:0] s, input logic [7:0] off);
    bus.en        = e;
    bus.sample_in = s;
    bus.offset    = off;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges and checks outputs before the next edge.
  task automatic do_reset(input string tag);
    bus.en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, " wr_en"},      32'(bus.wr_en),      32'd0);
    check({tag, " rd_en"},      32'(bus.rd_en),      32'd0);
    check({tag, " wr_addr"},    32'(bus.wr_addr),    32'd0);
    check({tag, " rd_addr"},    32'(bus.rd_addr),    32'd0);
    check({tag, " din"},        32'(bus.din),        32'd0);
    check({tag, " dout_valid"}, 32'(bus.dout_valid), 32'd0);
    check({tag, " filling"},    32'(bus.filling),    32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b1;
    bus.en        = 1'b0;
    bus.offset    = '0;
    bus.sample_in = '0;
    @(posedge clk);
    #1;
    do_reset("rst0");

    // offset 4, continuous strobes, through a pointer wrap.
    for (int k = 1; k <= 300; k++) begin
      tick(1'b1, 8'(k), 8'd4);
      check($sformatf("c4 wr_en k=%0d", k),   32'(bus.wr_en),   32'd1);
      check($sformatf("c4 wr_addr k=%0d", k), 32'(bus.wr_addr), 32'((k - 1) & 255));
      check($sformatf("c4 din k=%0d", k),     32'(bus.din),     32'(k & 255));
      check($sformatf("c4 filling k=%0d", k), 32'(bus.filling), 32'(k < 4));
      check($sformatf("c4 rd_en k=%0d", k),   32'(bus.rd_en),   32'(k >= 5));
      if (k >= 5)
        check($sformatf("c4 rd_addr k=%0d", k), 32'(bus.rd_addr), 32'((k - 5) & 255));
      check($sformatf("c4 dout_valid k=%0d", k), 32'(bus.dout_valid), 32'(k >= 6));
      if (k >= 6)
        check($sformatf("c4 dout k=%0d", k), 32'(ram_dout), 32'((k - 5) & 255));
      if (k == 258) begin
        check("wrap wr_addr", 32'(bus.wr_addr), 32'd1);
        check("wrap rd_addr", 32'(bus.rd_addr), 32'd253);
      end
    end

    // Mid-operation reset, then full-depth delay.
    do_reset("rst1");
    for (int k = 1; k <= 260; k++) begin
      tick(1'b1, 8'(k), 8'd0);
      check($sformatf("c0 filling k=%0d", k), 32'(bus.filling), 32'(k < 256));
      check($sformatf("c0 rd_en k=%0d", k),   32'(bus.rd_en),   32'(k >= 257));
      check($sformatf("c0 wr_addr k=%0d", k), 32'(bus.wr_addr), 32'((k - 1) & 255));
      if (k >= 257)
        check($sformatf("c0 rd_addr k=%0d", k), 32'(bus.rd_addr), 32'((k - 1) & 255));
      check($sformatf("c0 dout_valid k=%0d", k), 32'(bus.dout_valid), 32'(k >= 258));
      if (k >= 258)
        check($sformatf("c0 dout k=%0d", k), 32'(ram_dout), 32'((k - 257) & 255));
    end

    // Sparse strobes, offset 2; offset wiggles between strobes.
    do_reset("rst2");
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 8'(16 + i), 8'd2);
      check($sformatf("sp wr_en i=%0d", i),      32'(bus.wr_en),      32'd1);
      check($sformatf("sp wr_addr i=%0d", i),    32'(bus.wr_addr),    32'(i - 1));
      check($sformatf("sp din i=%0d", i),        32'(bus.din),        32'(16 + i));
      check($sformatf("sp filling i=%0d", i),    32'(bus.filling),    32'(i < 2));
      check($sformatf("sp rd_en i=%0d", i),      32'(bus.rd_en),      32'(i >= 3));
      if (i >= 3)
        check($sformatf("sp rd_addr i=%0d", i),  32'(bus.rd_addr),    32'(i - 3));
      check($sformatf("sp dv0 i=%0d", i),        32'(bus.dout_valid), 32'd0);
      tick(1'b0, 8'hee, 8'd9);
      check($sformatf("sp wr_en off i=%0d", i),  32'(bus.wr_en),      32'd0);
      check($sformatf("sp rd_en off i=%0d", i),  32'(bus.rd_en),      32'd0);
      check($sformatf("sp wr_hold i=%0d", i),    32'(bus.wr_addr),    32'(i - 1));
      check($sformatf("sp dv1 i=%0d", i),        32'(bus.dout_valid), 32'(i >= 3));
      if (i >= 3)
        check($sformatf("sp dout i=%0d", i),     32'(ram_dout),       32'(16 + i - 2));
      tick(1'b0, 8'hee, 8'd7);
      check($sformatf("sp dv2 i=%0d", i),        32'(bus.dout_valid), 32'd0);
    end

    // Offset change 4 -> 8 while running.
    do_reset("rst3");
    for (int k = 1; k <= 10; k++) tick(1'b1, 8'(k), 8'd4);
    check("oc pre rd_en", 32'(bus.rd_en), 32'd1);
    for (int k = 11; k <= 20; k++) begin
      tick(1'b1, 8'(k), 8'd8);
`ifdef DELAY_REFILL_EN
      check($sformatf("oc filling k=%0d", k), 32'(bus.filling), 32'(k <= 17));
      check($sformatf("oc rd_en k=%0d", k),   32'(bus.rd_en),   32'(k >= 19));
      if (k >= 19)
        check($sformatf("oc rd_addr k=%0d", k), 32'(bus.rd_addr), 32'(k - 9));
      check($sformatf("oc dout_valid k=%0d", k), 32'(bus.dout_valid), 32'(k == 11 || k == 20));
      if (k == 11) check("oc dout k=11", 32'(ram_dout), 32'd6);
      if (k == 20) check("oc dout k=20", 32'(ram_dout), 32'd11);
`else
      check($sformatf("oc filling k=%0d", k),    32'(bus.filling),    32'd0);
      check($sformatf("oc rd_en k=%0d", k),      32'(bus.rd_en),      32'd1);
      check($sformatf("oc rd_addr k=%0d", k),    32'(bus.rd_addr),    32'(k - 9));
      check($sformatf("oc dout_valid k=%0d", k), 32'(bus.dout_valid), 32'd1);
      check($sformatf("oc dout k=%0d", k),       32'(ram_dout),       32'((k == 11) ? 6 : k - 9));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
